axi_ni_initiator_response_unpacker: RTL
=======================================

// Module: axi_ni_initiator_response_unpacker
// PURPOSE
//  Initiator-side NI block that turns NoC read-response payloads into an AXI R-channel burst.
//  Unpacks data and the packet response code, restores byte order and maps the code to RRESP.
//  Counts beats to generate RLAST.
//  2-entry FIFO decouples the NoC flit side from AXI RREADY backpressure.
//  Sits between the initiator NI response depacketizer and the AXI master's R port.
// PARAMETERS
//  FLIT_WIDTH          32              NoC flit width; BASE_WIDTH = FLIT_WIDTH - `FTYPEWD
//  AXIRDATAWD          32              AXI read data width (multiple of 8)
//  AXIIDWD             4               AXI ID width
//  ENDIANNESS          `LITTLE_ENDIAN  `BIG_ENDIAN => byte-reverse payload data onto RDATA
//  RESP_PAYLOADLENGTH  (ni_parameters) response payload width; bits >= MAX_RP_RESP_WD ignored
// PORTS
//  clk            in   1                    clock, all state on posedge
//  rst            in   1                    synchronous, active-high reset
//  burst_start    in   1                    response header decoded; sample burst_len/id/excl
//  burst_len      in   8                    AXI ARLEN of burst (beats = burst_len+1)
//  burst_id       in   AXIIDWD              transaction ID to return on rid
//  burst_excl     in   1                    originating AR was exclusive (ARLOCK)
//  payload        in   RESP_PAYLOADLENGTH   data @RP_RESP_BASE_DATA, code @RP_RESP_BASE_RESP
//  payload_valid  in   1                    payload holds one beat
//  payload_ready  out  1                    beat accepted when valid & ready
//  rid            out  AXIIDWD              AXI RID
//  rdata          out  AXIRDATAWD           AXI RDATA
//  rresp          out  `AXIRESPWD           AXI RRESP
//  rlast          out  1                    AXI RLAST
//  rvalid         out  1                    AXI RVALID
//  rready         in   1                    AXI RREADY
//  busy           out  1                    1 while state != IDLE
//  err_count      out  16                   only with AXI_NI_RESP_ERR_COUNTER_EN
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, counters 0.
//   All outputs 0: rvalid, rlast, rdata, rresp, rid, payload_ready, busy, err_count.
//  FSM IDLE -> BURST on burst_start.
//   Registers len_q=burst_len, id_q=burst_id, excl_q=burst_excl.
//   Clears acc_cnt and out_cnt.
//  burst_start while in BURST is ignored; upstream holds the next header until busy=0.
//  payload_ready = (state==BURST) & (fifo_count<2) & (acc_cnt<=len_q).
//   Combinational from registered state only; never depends on payload_valid or rready.
//  Accept: push {swapped data, mapped resp}, then acc_cnt++.
//   Swap: byte i <- byte (N-1-i) when `BIG_ENDIAN, else identity.
//  RRESP mapping:
//   DVA:  EXOKAY if excl_q, else OKAY.
//   FAIL: OKAY (exclusive failed).
//   ERR:  SLVERR.
//   Any other code: SLVERR.
//  rvalid = FIFO non-empty; rdata/rresp come from the head entry; rid = id_q.
//   Latency: beat accepted in cycle N -> rvalid in cycle N+1 (registered FIFO).
//  rlast = rvalid & (out_cnt==len_q). Pop on rvalid & rready, then out_cnt++.
//  Head entry and rlast are held stable while rvalid & !rready (AXI rule).
//  Simultaneous push and pop:
//   fifo_count 1 -> stays 1.
//   fifo_count 2 -> no push (payload_ready=0), pop only.
//  Pop with rlast -> IDLE in the next cycle; burst_start can be sampled that cycle.
//  burst_len=0: a single beat, with rlast=1 on it.
//  burst_len=255: acc_cnt/out_cnt are 9 bits, so no wrap.
//  rst mid-burst: FIFO flushed, rvalid drops the next cycle; in-flight beats are lost by design.
// CONFIGURATION
//  AXI_NI_RESP_ERR_COUNTER_EN defined:
//   err_count increments on each popped beat with rresp==SLVERR.
//   Saturates at 16'hFFFF; reset to 0.
//  Not defined: err_count port absent, no counter logic.
// TESTING
//  1) len=3, 4 DVA beats D0..D3, rready=1 -> 4 R beats in order, rresp=00, rlast only on D3, busy->0.
//  2) excl=1, len=0, code DVA -> one beat, rresp=01 (EXOKAY), rlast=1.
//     Repeat with FAIL -> rresp=00.
//  3) ERR code on beat 2 of a len=3 burst -> that beat rresp=10, others 00.
//     With AXI_NI_RESP_ERR_COUNTER_EN: err_count=1.
//  4) rready=0 for 5 cycles, valid stream -> exactly 2 beats accepted, then payload_ready=0.
//     rdata held stable; releasing rready drains with no loss or duplicates.
//  5) ENDIANNESS=`BIG_ENDIAN, data 32'h11223344 -> rdata=32'h44332211.
//  6) rst asserted after beat 1 of a len=7 burst -> next cycle rvalid=0, busy=0.
//     A new burst_start then completes normally.

Source files
------------

// File: rtl/axi_ni_initiator_response_unpacker.sv
// Initiator NI read-response unpacker: NoC payload beats -> AXI R channel via a 2-entry FIFO.
// Optional AXI_NI_RESP_ERR_COUNTER_EN adds a saturating SLVERR beat counter on err_count.
`ifndef FTYPEWD
`define FTYPEWD 2
`endif
`ifndef LITTLE_ENDIAN
`define LITTLE_ENDIAN 0
`endif
`ifndef BIG_ENDIAN
`define BIG_ENDIAN 1
`endif
`ifndef AXIRESPWD
`define AXIRESPWD 2
`endif

module axi_ni_initiator_response_unpacker #(
  parameter int FLIT_WIDTH         = 32,
  parameter int AXIRDATAWD         = 32,
  parameter int AXIIDWD            = 4,
  parameter int ENDIANNESS         = `LITTLE_ENDIAN,
  parameter int RP_RESP_BASE_RESP  = 0,
  parameter int RP_RESP_CODE_WD    = 2,
  parameter int RP_RESP_BASE_DATA  = 2,
  parameter int RESP_PAYLOADLENGTH = RP_RESP_BASE_DATA + AXIRDATAWD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          burst_start,
  input  logic [7:0]                    burst_len,
  input  logic [AXIIDWD-1:0]            burst_id,
  input  logic                          burst_excl,
  input  logic [RESP_PAYLOADLENGTH-1:0] payload,
  input  logic                          payload_valid,
  output logic                          payload_ready,
  output logic [AXIIDWD-1:0]            rid,
  output logic [AXIRDATAWD-1:0]         rdata,
  output logic [`AXIRESPWD-1:0]         rresp,
  output logic                          rlast,
  output logic                          rvalid,
  input  logic                          rready,
  output logic                          busy
`ifdef AXI_NI_RESP_ERR_COUNTER_EN
  ,
  output logic [15:0]                   err_count
`endif
);

  localparam int BASE_WIDTH = FLIT_WIDTH - `FTYPEWD;

  if (BASE_WIDTH < 1) begin : g_flit_check
    $error("FLIT_WIDTH leaves no room for a flit payload");
  end

  localparam logic [RP_RESP_CODE_WD-1:0] CODE_DVA  = RP_RESP_CODE_WD'(0);
  localparam logic [RP_RESP_CODE_WD-1:0] CODE_FAIL = RP_RESP_CODE_WD'(1);
  localparam logic [RP_RESP_CODE_WD-1:0] CODE_ERR  = RP_RESP_CODE_WD'(2);

  localparam logic [`AXIRESPWD-1:0] RRESP_OKAY   = `AXIRESPWD'(0);
  localparam logic [`AXIRESPWD-1:0] RRESP_EXOKAY = `AXIRESPWD'(1);
  localparam logic [`AXIRESPWD-1:0] RRESP_SLVERR = `AXIRESPWD'(2);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  function automatic logic [AXIRDATAWD-1:0] byte_order(input logic [AXIRDATAWD-1:0] d);
    logic [AXIRDATAWD-1:0] r;
    r = d;
    if (ENDIANNESS == `BIG_ENDIAN) begin
      for (int i = 0; i < AXIRDATAWD / 8; i++) begin
        r[8*i +: 8] = d[AXIRDATAWD-8-8*i +: 8];
      end
    end
    return r;
  endfunction

  // A FAIL code means the exclusive access lost its reservation: plain OKAY, not an error.
  function automatic logic [`AXIRESPWD-1:0] map_resp(input logic [RP_RESP_CODE_WD-1:0] code,
                                                     input logic excl);
    logic [`AXIRESPWD-1:0] r;
    case (code)
      CODE_DVA:  r = excl ? RRESP_EXOKAY : RRESP_OKAY;
      CODE_FAIL: r = RRESP_OKAY;
      CODE_ERR:  r = RRESP_SLVERR;
      default:   r = RRESP_SLVERR;
    endcase
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [7:0]              len_q;
  logic [AXIIDWD-1:0]      id_q;
  logic                    excl_q;
  logic [8:0]              acc_cnt;
  logic [8:0]              out_cnt;
  logic [1:0]              fifo_count;
  logic                    wr_ptr, rd_ptr;
  logic [AXIRDATAWD-1:0]   mem_data [2];
  logic [`AXIRESPWD-1:0]   mem_resp [2];
  logic                    push, pop;

  assign push   = payload_valid & payload_ready;
  assign pop    = rvalid & rready;
  assign rvalid = (fifo_count != 2'd0);
  assign rdata  = rvalid ? mem_data[rd_ptr] : '0;
  assign rresp  = rvalid ? mem_resp[rd_ptr] : '0;
  assign rlast  = rvalid & (out_cnt == {1'b0, len_q});
  assign rid    = id_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (burst_start) state_d = BURST;
      BURST:   if (pop && rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    payload_ready = 1'b0;
    if (state_q == BURST) begin
      busy          = 1'b1;
      payload_ready = (fifo_count < 2'd2) && (acc_cnt <= {1'b0, len_q});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      id_q       <= '0;
      excl_q     <= 1'b0;
      acc_cnt    <= '0;
      out_cnt    <= '0;
      fifo_count <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
    end else begin
      if (state_q == IDLE && burst_start) begin
        len_q   <= burst_len;
        id_q    <= burst_id;
        excl_q  <= burst_excl;
        acc_cnt <= '0;
        out_cnt <= '0;
      end else begin
        if (push) acc_cnt <= acc_cnt + 9'd1;
        if (pop)  out_cnt <= out_cnt + 9'd1;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO storage carries no reset; outputs are masked by rvalid instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= byte_order(payload[RP_RESP_BASE_DATA +: AXIRDATAWD]);
      mem_resp[wr_ptr] <= map_resp(payload[RP_RESP_BASE_RESP +: RP_RESP_CODE_WD], excl_q);
    end
  end

`ifdef AXI_NI_RESP_ERR_COUNTER_EN
  logic [15:0] err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else if (pop && rresp == RRESP_SLVERR && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
  end

  assign err_count = err_q;
`endif

endmodule
